mdu: RTL

- Multiply/divide unit in the E stage, beside the ALU. It takes the same SrcA/SrcB operand pair and a control code from the controller.
- It runs multi-cycle MULT/DIV operations and owns the HI/LO registers.
- It raises busy so the hazard unit can stall the D stage on any following HI/LO-related instruction.

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mdu.sv | 89 ++++++++
 2 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared MDU control codes, default latencies and the long-op predicate.
// Shared by the mdu block and the controller so both decode MDUCtrl identically.
// Build option: MDU_MADD_EN adds MADD/MADDU to the long-op set; without it those
// codes decode as NOP.
package mdu_pkg;

   localparam logic [3:0] MDU_NOP   = 4'd0;
   localparam logic [3:0] MDU_MULT  = 4'd1;
   localparam logic [3:0] MDU_MULTU = 4'd2;
   localparam logic [3:0] MDU_DIV   = 4'd3;
   localparam logic [3:0] MDU_DIVU  = 4'd4;
   localparam logic [3:0] MDU_MFHI  = 4'd5;
   localparam logic [3:0] MDU_MFLO  = 4'd6;
   localparam logic [3:0] MDU_MTHI  = 4'd7;
   localparam logic [3:0] MDU_MTLO  = 4'd8;
   localparam logic [3:0] MDU_MADD  = 4'd9;
   localparam logic [3:0] MDU_MADDU = 4'd10;

   localparam int MUL_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF = 10;

   function automatic logic is_long_op(input logic [3:0] c);
`ifdef MDU_MADD_EN
      return c inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MADD, MDU_MADDU};
`else
      return c inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU};
`endif
   endfunction

endpackage

// File: rtl/mdu.sv
// mdu: E-stage multiply/divide unit owning HI/LO, with a busy flag for D-stage stalls.
// Ports:
//   clk, reset    clock and synchronous active-high reset (clears all state)
//   start         MDUCtrl is a valid MDU op this cycle
//   MDUCtrl [3:0] operation code (see mdu_pkg)
//   SrcA, SrcB    forwarded rs / rt operands
//   busy          a MULT/DIV-class operation is in flight
//   MDUOut        MFHI/MFLO read data (combinational from HI/LO)
//   HI, LO        architectural HI/LO registers
// Build option: MDU_MADD_EN enables MADD/MADDU (decoded through mdu_pkg::is_long_op).
module mdu
   import mdu_pkg::*;
#(
   parameter int MUL_CYCLES = MUL_CYCLES_DEF,
   parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  MDUCtrl,
   input  logic [31:0] SrcA,
   input  logic [31:0] SrcB,
   output logic        busy,
   output logic [31:0] MDUOut,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int CW = $clog2((MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES) + 1);

   logic [CW-1:0] cnt;
   logic [31:0]   pend_hi, pend_lo;
   logic [63:0]   hl, ps, pu, res;
   logic [31:0]   db, q_s, r_s, q_u, r_u;
   logic          dz, ovf, is_div;

   // The result is computed at the start edge and parked in pend_*; the
   // counter only models latency. A zero divisor parks the current HI/LO so the
   // eventual commit is a no-op. The divisor is forced to 1 for both zero and
   // the 0x80000000 / -1 overflow case, which yields the required LO=0x80000000,
   // HI=0 without relying on simulator behaviour for undefined division.
   always_comb begin
      hl     = {HI, LO};
      ps     = {{32{SrcA[31]}}, SrcA} * {{32{SrcB[31]}}, SrcB};
      pu     = {32'b0, SrcA} * {32'b0, SrcB};
      dz     = SrcB == '0;
      ovf    = SrcA == 32'h8000_0000 && SrcB == '1;
      db     = (dz || ovf) ? 32'd1 : SrcB;
      q_s    = $signed(SrcA) / $signed(db);
      r_s    = $signed(SrcA) % $signed(db);
      q_u    = SrcA / db;
      r_u    = SrcA % db;
      is_div = MDUCtrl == MDU_DIV || MDUCtrl == MDU_DIVU;
      res    = MDUCtrl == MDU_MULT  ? ps :
               MDUCtrl == MDU_MULTU ? pu :
               (is_div && dz)       ? hl :
               MDUCtrl == MDU_DIV   ? {r_s, q_s} :
               MDUCtrl == MDU_DIVU  ? {r_u, q_u} :
               MDUCtrl == MDU_MADD  ? hl + ps : hl + pu;
   end

   assign busy   = cnt != '0;
   assign MDUOut = MDUCtrl == MDU_MFLO ? LO : HI;

   // Requests arriving while busy fall through the first branch untouched.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         HI      <= '0;
         LO      <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
      end else if (cnt != '0) begin
         cnt <= cnt - CW'(1);
         if (cnt == CW'(1)) begin
            HI <= pend_hi;
            LO <= pend_lo;
         end
      end else if (start) begin
         if (is_long_op(MDUCtrl)) begin
            {pend_hi, pend_lo} <= res;
            cnt <= is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
         end
         if (MDUCtrl == MDU_MTHI) HI <= SrcA;
         if (MDUCtrl == MDU_MTLO) LO <= SrcA;
      end
   end

endmodule
